// File: rtl/kd_pkg.sv
// Shared definitions for the k-d tree cluster-center cells: widths, command codes, node states.
package kd_pkg;

  localparam int CMD_W  = 5;
  localparam int DATA_W = 24;

  localparam logic [CMD_W-1:0] CMD_NOP                      = 5'b00000;
  localparam logic [CMD_W-1:0] CMD_CENTER_FILL              = 5'b00001;
  localparam logic [CMD_W-1:0] CMD_CONFIGURE_SORT_AXIS      = 5'b00010;
  localparam logic [CMD_W-1:0] CMD_RECIEVE_CENTER           = 5'b00011;
  localparam logic [CMD_W-1:0] CMD_SWITCH_WITH_LEFT         = 5'b00100;
  localparam logic [CMD_W-1:0] CMD_CENTER_FILL_DONE         = 5'b00101;
  localparam logic [CMD_W-1:0] CMD_CONFIGURE_SORT_AXIS_DONE = 5'b00111;
  localparam logic [CMD_W-1:0] CMD_BUSY                     = 5'b01000;
  localparam logic [CMD_W-1:0] CMD_DNE                      = 5'b10000;
  localparam logic [CMD_W-1:0] CMD_RST_DONE                 = 5'b11110;
  localparam logic [CMD_W-1:0] CMD_RST                      = 5'b11111;

  typedef enum logic [2:0] {
    IDLE,
    RST_WAIT,
    RST_DONE,
    FILL_WAIT,
    AXIS_WAIT
  } state_t;

  // Sort axis used one level further down the tree (R -> G -> B -> R).
  function automatic logic [1:0] next_axis(input logic [1:0] a);
    case (a)
      2'd0:    next_axis = 2'd1;
      2'd1:    next_axis = 2'd2;
      2'd2:    next_axis = 2'd0;
      default: next_axis = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/node.sv
// One k-d tree cell: stores a 24-bit RGB center and relays reset, fill and axis
// configuration to its left/right children, reporting status upward.
//
// state     | meaning
// IDLE      | ready; status word reflects whether the subtree is full
// RST_WAIT  | rst forwarded, waiting for children to report rst_done
// RST_DONE  | subtree reset, holding rst_done while top stays rst
// FILL_WAIT | center_fill forwarded to one child, waiting for it to settle
// AXIS_WAIT | configure_sort_axis forwarded, waiting for children / top release
module node
  import kd_pkg::*;
#(
  parameter logic [39:0] NAME = "node "
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_from_top,
  input  logic [DATA_W-1:0] data_from_left,
  input  logic [DATA_W-1:0] data_from_right,
  input  logic [CMD_W-1:0]  command_from_top,
  input  logic [CMD_W-1:0]  command_from_left,
  input  logic [CMD_W-1:0]  command_from_right,
  output logic [DATA_W-1:0] data_to_top,
  output logic [DATA_W-1:0] data_to_left,
  output logic [DATA_W-1:0] data_to_right,
  output logic [CMD_W-1:0]  command_to_top,
  output logic [CMD_W-1:0]  command_to_left,
  output logic [CMD_W-1:0]  command_to_right
);

  state_t            r_state;
  logic              r_guard;
  logic              r_center_valid;
  logic [DATA_W-1:0] r_center;
  logic [1:0]        r_axis;
  logic              r_turn;        // 0 = left child gets the next fill
  logic              r_fill_right;
  logic [CMD_W-1:0]  r_cmd_top, r_cmd_left, r_cmd_right;
  logic [DATA_W-1:0] r_data_left, r_data_right;

  logic w_left_present, w_right_present;
  logic w_left_full, w_right_full, w_full;
  logic w_rst_ok, w_axis_ok, w_pick_right;
  logic [CMD_W-1:0] w_status;
  logic w_unused;

  assign w_left_present  = command_from_left  != CMD_DNE;
  assign w_right_present = command_from_right != CMD_DNE;
  assign w_left_full  = !w_left_present  || command_from_left  == CMD_CENTER_FILL_DONE;
  assign w_right_full = !w_right_present || command_from_right == CMD_CENTER_FILL_DONE;
  assign w_full   = r_center_valid && w_left_full && w_right_full;
  assign w_status = w_full ? CMD_CENTER_FILL_DONE : CMD_NOP;
  assign w_rst_ok = (!w_left_present || command_from_left == CMD_RST_DONE) &&
                    (!w_right_present || command_from_right == CMD_RST_DONE);
  assign w_axis_ok = (!w_left_present || command_from_left == CMD_CONFIGURE_SORT_AXIS_DONE) &&
                     (!w_right_present || command_from_right == CMD_CONFIGURE_SORT_AXIS_DONE);
  assign w_pick_right = r_turn ? !w_right_full : w_left_full;

  // Child status data and the label carry no function here.
  assign w_unused = &{1'b0, data_from_left, data_from_right, NAME};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_guard        <= 1'b0;
      r_center_valid <= 1'b0;
      r_center       <= '0;
      r_axis         <= 2'd0;
      r_turn         <= 1'b0;
      r_fill_right   <= 1'b0;
      r_cmd_top      <= CMD_NOP;
      r_cmd_left     <= CMD_NOP;
      r_cmd_right    <= CMD_NOP;
      r_data_left    <= '0;
      r_data_right   <= '0;
    end else begin
      r_cmd_left   <= CMD_NOP;
      r_cmd_right  <= CMD_NOP;
      r_data_left  <= '0;
      r_data_right <= '0;
      if (command_from_top == CMD_RST && r_state != RST_WAIT && r_state != RST_DONE) begin
        r_center_valid <= 1'b0;
        r_center       <= '0;
        r_axis         <= 2'd0;
        r_turn         <= 1'b0;
        r_cmd_left     <= w_left_present  ? CMD_RST : CMD_NOP;
        r_cmd_right    <= w_right_present ? CMD_RST : CMD_NOP;
        r_cmd_top      <= CMD_BUSY;
        r_guard        <= 1'b1;
        r_state        <= RST_WAIT;
      end else begin
        case (r_state)
          RST_WAIT: begin
            r_cmd_left  <= w_left_present  ? CMD_RST : CMD_NOP;
            r_cmd_right <= w_right_present ? CMD_RST : CMD_NOP;
            if (r_guard) begin
              r_guard <= 1'b0;
            end else if (w_rst_ok) begin
              r_cmd_top <= CMD_RST_DONE;
              r_state   <= RST_DONE;
            end
          end
          FILL_WAIT: begin
            if (r_guard) begin
              r_guard <= 1'b0;
            end else if ((r_fill_right ? command_from_right : command_from_left) != CMD_BUSY) begin
              r_cmd_top <= w_status;
              r_state   <= IDLE;
            end
          end
          AXIS_WAIT: begin
            r_cmd_left   <= w_left_present  ? CMD_CONFIGURE_SORT_AXIS : CMD_NOP;
            r_cmd_right  <= w_right_present ? CMD_CONFIGURE_SORT_AXIS : CMD_NOP;
            r_data_left  <= w_left_present  ? {22'd0, next_axis(r_axis)} : '0;
            r_data_right <= w_right_present ? {22'd0, next_axis(r_axis)} : '0;
            if (r_guard) begin
              r_guard <= 1'b0;
            end else if (r_cmd_top != CMD_CONFIGURE_SORT_AXIS_DONE) begin
              if (w_axis_ok) r_cmd_top <= CMD_CONFIGURE_SORT_AXIS_DONE;
            end else if (command_from_top != CMD_CONFIGURE_SORT_AXIS) begin
              r_cmd_left   <= CMD_NOP;
              r_cmd_right  <= CMD_NOP;
              r_data_left  <= '0;
              r_data_right <= '0;
              r_cmd_top    <= w_status;
              r_state      <= IDLE;
            end
          end
          default: begin
            if (r_state == RST_DONE && command_from_top == CMD_RST) begin
              r_cmd_left  <= w_left_present  ? CMD_RST : CMD_NOP;
              r_cmd_right <= w_right_present ? CMD_RST : CMD_NOP;
            end else begin
              r_state <= IDLE;
              case (command_from_top)
                CMD_CENTER_FILL: begin
                  if (!r_center_valid) begin
                    r_center       <= data_from_top;
                    r_center_valid <= 1'b1;
                    r_cmd_top <= (w_left_full && w_right_full) ? CMD_CENTER_FILL_DONE : CMD_NOP;
                  end else if (!w_full) begin
                    if (w_pick_right) begin
                      r_cmd_right  <= CMD_CENTER_FILL;
                      r_data_right <= data_from_top;
                    end else begin
                      r_cmd_left  <= CMD_CENTER_FILL;
                      r_data_left <= data_from_top;
                    end
                    r_fill_right <= w_pick_right;
                    r_turn       <= ~r_turn;
                    r_cmd_top    <= CMD_BUSY;
                    r_guard      <= 1'b1;
                    r_state      <= FILL_WAIT;
                  end else begin
                    r_cmd_top <= w_status;
                  end
                end
                CMD_CONFIGURE_SORT_AXIS: begin
                  r_axis       <= data_from_top[1:0];
                  r_cmd_left   <= w_left_present  ? CMD_CONFIGURE_SORT_AXIS : CMD_NOP;
                  r_cmd_right  <= w_right_present ? CMD_CONFIGURE_SORT_AXIS : CMD_NOP;
                  r_data_left  <= w_left_present  ? {22'd0, next_axis(data_from_top[1:0])} : '0;
                  r_data_right <= w_right_present ? {22'd0, next_axis(data_from_top[1:0])} : '0;
                  r_cmd_top    <= CMD_BUSY;
                  r_guard      <= 1'b1;
                  r_state      <= AXIS_WAIT;
                end
                default: r_cmd_top <= w_status;
              endcase
            end
          end
        endcase
      end
    end
  end

  assign data_to_top      = r_center;
  assign data_to_left     = r_data_left;
  assign data_to_right    = r_data_right;
  assign command_to_top   = r_cmd_top;
  assign command_to_left  = r_cmd_left;
  assign command_to_right = r_cmd_right;

endmodule

// File: tb/tb_node.sv
// Bench for node: a three-node tree (root + two leaves) driven as the controller,
// plus a standalone leaf, checked against a fill-order / axis reference model.
module tb_node;
  import kd_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [CMD_W-1:0]  top_cmd = CMD_NOP;
  logic [DATA_W-1:0] top_data = '0;

  logic [DATA_W-1:0] root_data_up, root_dl, root_dr, l_data_up, r_data_up;
  logic [DATA_W-1:0] l_dl, l_dr, r_dl, r_dr;
  logic [CMD_W-1:0]  root_status, root_cl, root_cr, l_status, r_status;
  logic [CMD_W-1:0]  l_cl, l_cr, r_cl, r_cr;

  logic              solo_reset = 1'b0;
  logic [CMD_W-1:0]  solo_cmd = CMD_NOP;
  logic [DATA_W-1:0] solo_data = '0;
  logic [DATA_W-1:0] solo_up, solo_dl, solo_dr;
  logic [CMD_W-1:0]  solo_status, solo_cl, solo_cr;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] exp_center [3];
  int                exp_count;

  always #5 clk = ~clk;

  node #(.NAME("root ")) u_root (
    .clk(clk), .reset(reset),
    .data_from_top(top_data), .data_from_left(l_data_up), .data_from_right(r_data_up),
    .command_from_top(top_cmd), .command_from_left(l_status), .command_from_right(r_status),
    .data_to_top(root_data_up), .data_to_left(root_dl), .data_to_right(root_dr),
    .command_to_top(root_status), .command_to_left(root_cl), .command_to_right(root_cr));

  node #(.NAME("left ")) u_left (
    .clk(clk), .reset(reset),
    .data_from_top(root_dl), .data_from_left(24'd0), .data_from_right(24'd0),
    .command_from_top(root_cl), .command_from_left(CMD_DNE), .command_from_right(CMD_DNE),
    .data_to_top(l_data_up), .data_to_left(l_dl), .data_to_right(l_dr),
    .command_to_top(l_status), .command_to_left(l_cl), .command_to_right(l_cr));

  node #(.NAME("right")) u_right (
    .clk(clk), .reset(reset),
    .data_from_top(root_dr), .data_from_left(24'd0), .data_from_right(24'd0),
    .command_from_top(root_cr), .command_from_left(CMD_DNE), .command_from_right(CMD_DNE),
    .data_to_top(r_data_up), .data_to_left(r_dl), .data_to_right(r_dr),
    .command_to_top(r_status), .command_to_left(r_cl), .command_to_right(r_cr));

  node #(.NAME("solo ")) u_solo (
    .clk(clk), .reset(solo_reset),
    .data_from_top(solo_data), .data_from_left(24'd0), .data_from_right(24'd0),
    .command_from_top(solo_cmd), .command_from_left(CMD_DNE), .command_from_right(CMD_DNE),
    .data_to_top(solo_up), .data_to_left(solo_dl), .data_to_right(solo_dr),
    .command_to_top(solo_status), .command_to_left(solo_cl), .command_to_right(solo_cr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the k-th accepted center lands in root, left, right in that order.
  task automatic model_clear();
    for (int i = 0; i < 3; i++) exp_center[i] = '0;
    exp_count = 0;
  endtask

  task automatic model_fill(input logic [DATA_W-1:0] v);
    if (exp_count < 3) begin
      exp_center[exp_count] = v;
      exp_count++;
    end
  endtask

  task automatic tree_rst(output int lat, output bit ok);
    top_cmd = CMD_RST;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (root_status != CMD_RST_DONE && lat < 12);
    ok = (root_status == CMD_RST_DONE);
    tick();
    top_cmd = CMD_NOP;
    tick();
    tick();
  endtask

  task automatic fill_one(input logic [DATA_W-1:0] v, output bit ok);
    int n;
    ok = 1'b1;
    n = 0;
    while (root_status == CMD_BUSY && n < 40) begin tick(); n++; end
    if (root_status == CMD_BUSY) ok = 1'b0;
    top_cmd = CMD_CENTER_FILL;
    top_data = v;
    tick();
    top_cmd = CMD_NOP;
    top_data = '0;
    n = 0;
    while (root_status == CMD_BUSY && n < 40) begin tick(); n++; end
    if (root_status == CMD_BUSY) ok = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if (root_status !== CMD_NOP || root_cl !== CMD_NOP || root_cr !== CMD_NOP) begin
      n_errors++;
      $display("FAIL reset_cmds: got top=%b left=%b right=%b, want all %b", root_status, root_cl, root_cr, CMD_NOP);
    end
    n_checks++;
    if (root_data_up !== 24'd0 || root_dl !== 24'd0 || root_dr !== 24'd0) begin
      n_errors++;
      $display("FAIL reset_data: got %h %h %h, want 0", root_data_up, root_dl, root_dr);
    end
  endtask

  task automatic test_tree_rst();
    int lat;
    bit ok;
    tree_rst(lat, ok);
    model_clear();
    n_checks++;
    if (!ok || lat > 6) begin
      n_errors++;
      $display("FAIL rst_latency: got %0d cycles (reached=%0d), want rst_done within 6", lat, ok);
    end
    n_checks++;
    if ({root_data_up, l_data_up, r_data_up} !== 72'd0) begin
      n_errors++;
      $display("FAIL rst_centers: got %h %h %h, want 0", root_data_up, l_data_up, r_data_up);
    end
  endtask

  task automatic test_fill();
    logic [DATA_W-1:0] vals [3];
    bit ok;
    vals[0] = 24'h112233; vals[1] = 24'h445566; vals[2] = 24'h778899;
    for (int i = 0; i < 3; i++) begin
      fill_one(vals[i], ok);
      model_fill(vals[i]);
      n_checks++;
      if (!ok) begin
        n_errors++;
        $display("FAIL fill_timeout: item %0d status stuck at %b, want not busy", i, root_status);
      end
    end
    n_checks++;
    if (root_data_up !== exp_center[0] || l_data_up !== exp_center[1] || r_data_up !== exp_center[2]) begin
      n_errors++;
      $display("FAIL fill_centers: got %h %h %h, want %h %h %h", root_data_up, l_data_up, r_data_up,
               exp_center[0], exp_center[1], exp_center[2]);
    end
    n_checks++;
    if (root_status !== CMD_CENTER_FILL_DONE) begin
      n_errors++;
      $display("FAIL fill_status: got %b, want %b", root_status, CMD_CENTER_FILL_DONE);
    end
  endtask

  task automatic test_full_drop();
    bit ok;
    fill_one(24'hAABBCC, ok);
    model_fill(24'hAABBCC);
    n_checks++;
    if (root_data_up !== exp_center[0] || l_data_up !== exp_center[1] || r_data_up !== exp_center[2]) begin
      n_errors++;
      $display("FAIL full_drop_centers: got %h %h %h, want %h %h %h", root_data_up, l_data_up, r_data_up,
               exp_center[0], exp_center[1], exp_center[2]);
    end
    tick();
    n_checks++;
    if (root_status !== CMD_CENTER_FILL_DONE) begin
      n_errors++;
      $display("FAIL full_drop_status: got %b, want %b", root_status, CMD_CENTER_FILL_DONE);
    end
  endtask

  task automatic test_mid_fill_rst();
    int lat;
    bit ok;
    test_tree_rst();
    fill_one(24'h0A0B0C, ok);
    tree_rst(lat, ok);
    model_clear();
    n_checks++;
    if (!ok || {root_data_up, l_data_up, r_data_up} !== 72'd0) begin
      n_errors++;
      $display("FAIL midfill_rst: reached=%0d centers %h %h %h, want rst_done and 0", ok,
               root_data_up, l_data_up, r_data_up);
    end
    test_fill();
  endtask

  task automatic test_axis(input logic [1:0] a);
    int n;
    logic [1:0] exp_child;
    exp_child = (a == 2'd2) ? 2'd0 : a + 2'd1;
    top_cmd = CMD_CONFIGURE_SORT_AXIS;
    top_data = {22'd0, a};
    n = 0;
    do begin tick(); n++; end while (root_status != CMD_CONFIGURE_SORT_AXIS_DONE && n < 30);
    n_checks++;
    if (root_status !== CMD_CONFIGURE_SORT_AXIS_DONE) begin
      n_errors++;
      $display("FAIL axis_done: got %b, want %b", root_status, CMD_CONFIGURE_SORT_AXIS_DONE);
    end
    n_checks++;
    if (u_root.r_axis !== a || u_left.r_axis !== exp_child || u_right.r_axis !== exp_child) begin
      n_errors++;
      $display("FAIL axis_values: got root=%0d left=%0d right=%0d, want %0d %0d %0d",
               u_root.r_axis, u_left.r_axis, u_right.r_axis, a, exp_child, exp_child);
    end
    top_cmd = CMD_NOP;
    top_data = '0;
    tick();
    tick();
    tick();
    n_checks++;
    if (root_status !== ((exp_count >= 3) ? CMD_CENTER_FILL_DONE : CMD_NOP)) begin
      n_errors++;
      $display("FAIL axis_release: got %b, want %b", root_status,
               (exp_count >= 3) ? CMD_CENTER_FILL_DONE : CMD_NOP);
    end
  endtask

  task automatic test_random();
    int lat, cnt;
    bit ok;
    logic [DATA_W-1:0] v;
    for (int it = 0; it < 5; it++) begin
      tree_rst(lat, ok);
      model_clear();
      n_checks++;
      if (!ok) begin
        n_errors++;
        $display("FAIL rand_rst: iteration %0d status %b, want %b", it, root_status, CMD_RST_DONE);
      end
      cnt = $urandom_range(1, 4);
      for (int k = 0; k < cnt; k++) begin
        v = 24'($urandom);
        fill_one(v, ok);
        model_fill(v);
      end
      n_checks++;
      if (root_data_up !== exp_center[0] || l_data_up !== exp_center[1] || r_data_up !== exp_center[2]) begin
        n_errors++;
        $display("FAIL rand_centers: it %0d got %h %h %h, want %h %h %h", it, root_data_up, l_data_up,
                 r_data_up, exp_center[0], exp_center[1], exp_center[2]);
      end
      n_checks++;
      if (root_status !== ((exp_count >= 3) ? CMD_CENTER_FILL_DONE : CMD_NOP)) begin
        n_errors++;
        $display("FAIL rand_status: it %0d got %b, want %b", it, root_status,
                 (exp_count >= 3) ? CMD_CENTER_FILL_DONE : CMD_NOP);
      end
      test_axis(2'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_leaf();
    solo_cmd = CMD_CENTER_FILL;
    solo_data = 24'hFFFFFF;
    tick();
    solo_reset = 1'b1;
    solo_cmd = CMD_NOP;
    tick();
    solo_reset = 1'b0;
    n_checks++;
    if (solo_status !== CMD_NOP || solo_cl !== CMD_NOP || solo_cr !== CMD_NOP ||
        solo_up !== 24'd0 || solo_dl !== 24'd0 || solo_dr !== 24'd0) begin
      n_errors++;
      $display("FAIL leaf_reset: got cmd %b %b %b data %h %h %h, want nop and 0",
               solo_status, solo_cl, solo_cr, solo_up, solo_dl, solo_dr);
    end
    solo_cmd = CMD_CENTER_FILL;
    solo_data = 24'h010203;
    tick();
    solo_cmd = CMD_NOP;
    solo_data = '0;
    n_checks++;
    if (solo_up !== 24'h010203 || solo_status !== CMD_CENTER_FILL_DONE) begin
      n_errors++;
      $display("FAIL leaf_fill: got %h/%b, want 010203/%b", solo_up, solo_status, CMD_CENTER_FILL_DONE);
    end
    solo_cmd = CMD_CENTER_FILL;
    solo_data = 24'h999999;
    tick();
    solo_cmd = CMD_NOP;
    tick();
    n_checks++;
    if (solo_up !== 24'h010203 || solo_status !== CMD_CENTER_FILL_DONE || solo_cl !== CMD_NOP) begin
      n_errors++;
      $display("FAIL leaf_full_drop: got %h/%b child %b, want 010203/%b nop", solo_up, solo_status,
               solo_cl, CMD_CENTER_FILL_DONE);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_tree_rst();
    test_fill();
    test_full_drop();
    test_mid_fill_rst();
    test_axis(2'd2);
    test_random();
    test_leaf();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
